// File: rtl/spi_pkg.sv
// Shared types and constants for the clk-domain SPI slave bridge.
// Modes are encoded as {cpol, cpha} pairs.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
   localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
   localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
   localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

   // The read/write flag is the MSB of the command word.
   localparam int RW_BIT_FROM_MSB = 0;

   function automatic int rw_bit(input int data_w);
      return data_w - 1 - RW_BIT_FROM_MSB;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Oversamples the asynchronous SPI pins into clk and turns sclk transitions
// into one-cycle sample/shift strobes plus chip-select edge strobes.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic mosi_s,
   output logic sample_edge,
   output logic shift_edge,
   output logic cs_fall,
   output logic cs_rise
);
   import spi_pkg::*;

   logic [SYNC_STAGES-1:0] sclk_sr;
   logic [SYNC_STAGES-1:0] cs_sr;
   logic [SYNC_STAGES-1:0] mosi_sr;
   logic                   sclk_d;
   logic                   cs_d;
   logic [SYNC_STAGES:0]   flush_sr;
   logic                   armed;
   logic                   sclk_s;
   logic                   cs_n_s;
   logic                   leading;
   logic                   trailing;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sr  <= {SYNC_STAGES{CPOL}};
         cs_sr    <= '1;
         mosi_sr  <= '0;
         sclk_d   <= CPOL;
         cs_d     <= 1'b1;
         flush_sr <= '0;
         armed    <= 1'b0;
      end else begin
         sclk_sr  <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         cs_sr    <= {cs_sr[SYNC_STAGES-2:0], cs_n};
         mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], mosi};
         sclk_d   <= sclk_s;
         cs_d     <= cs_n_s;
         flush_sr <= {flush_sr[SYNC_STAGES-1:0], 1'b1};
         // A frame may only start once cs_n has really been seen high after reset;
         // the idle values preloaded into the chain do not count.
         if (flush_sr[SYNC_STAGES] && cs_d && cs_n_s) armed <= 1'b1;
      end
   end

   assign sclk_s      = sclk_sr[SYNC_STAGES-1];
   assign cs_n_s      = cs_sr[SYNC_STAGES-1];
   assign mosi_s      = mosi_sr[SYNC_STAGES-1];

   assign leading     = (sclk_d == CPOL) && (sclk_s != CPOL);
   assign trailing    = (sclk_d != CPOL) && (sclk_s == CPOL);
   assign sample_edge = CPHA ? trailing : leading;
   assign shift_edge  = CPHA ? leading  : trailing;

   assign cs_fall     = armed && cs_d && !cs_n_s;
   assign cs_rise     = !cs_d && cs_n_s;

endmodule

// File: rtl/spi_bridge_sync.sv
// SPI slave to register-file bridge: command word (rw + address) followed by
// a burst of data words with address auto-increment, all in the clk domain.
module spi_bridge_sync #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 6,
   parameter bit          CPOL        = 1'b0,
   parameter bit          CPHA        = 1'b0,
   parameter int          SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic              cmd_valid,
   output logic              cmd_rw,
   output logic [ADDR_W-1:0] reg_addr,
   output logic              wr_valid,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_req,
   input  logic [DATA_W-1:0] rd_data
);
   import spi_pkg::*;

   localparam int CNT_W  = $clog2(DATA_W);
   localparam int RW_BIT = rw_bit(DATA_W);

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   bit_cnt;
   logic [DATA_W-2:0]  rx_sh;
   logic [DATA_W-1:0]  tx_sh;
   logic [DATA_W-1:0]  rx_word;
   logic               last_bit;
   logic               frame_clr;
   logic               sample_ok;
   logic               shift_ok;
   logic               mosi_s;
   logic               sample_edge;
   logic               shift_edge;
   logic               cs_fall;
   logic               cs_rise;

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .CPOL        (CPOL),
      .CPHA        (CPHA)
   ) u_sync_edge (
      .clk         (clk),
      .rst         (rst),
      .sclk        (sclk),
      .cs_n        (cs_n),
      .mosi        (mosi),
      .mosi_s      (mosi_s),
      .sample_edge (sample_edge),
      .shift_edge  (shift_edge),
      .cs_fall     (cs_fall),
      .cs_rise     (cs_rise)
   );

   assign rx_word  = {rx_sh, mosi_s};
   assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path infers a latch.
      state_d   = state_q;
      frame_clr = 1'b0;
      sample_ok = 1'b0;
      shift_ok  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d   = CMD;
               frame_clr = 1'b1;
            end
         end
         CMD: begin
            // cs_n rising beats a coincident sample edge.
            if (cs_rise) begin
               state_d   = IDLE;
               frame_clr = 1'b1;
            end else if (sample_edge) begin
               sample_ok = 1'b1;
               if (last_bit) state_d = DATA;
            end
         end
         DATA: begin
            if (cs_rise) begin
               state_d   = IDLE;
               frame_clr = 1'b1;
            end else begin
               sample_ok = sample_edge;
               // The shift edge right after a word boundary only presents the freshly loaded MSB.
               shift_ok  = shift_edge && cmd_rw && (bit_cnt != '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= '0;
         rx_sh     <= '0;
         tx_sh     <= '0;
         cmd_valid <= 1'b0;
         cmd_rw    <= 1'b0;
         reg_addr  <= '0;
         wr_valid  <= 1'b0;
         wr_data   <= '0;
         rd_req    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         cmd_valid <= 1'b0;
         wr_valid  <= 1'b0;
         rd_req    <= 1'b0;
         if (wr_valid) reg_addr <= reg_addr + ADDR_W'(1);
         if (rd_req)   tx_sh    <= rd_data;
         if (frame_clr) begin
            bit_cnt <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
         end else if (sample_ok) begin
            rx_sh   <= rx_word[DATA_W-2:0];
            bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
            if (last_bit) begin
               if (state_q == CMD) begin
                  cmd_valid <= 1'b1;
                  cmd_rw    <= rx_word[RW_BIT];
                  reg_addr  <= rx_word[ADDR_W-1:0];
                  rd_req    <= rx_word[RW_BIT];
               end else if (cmd_rw) begin
                  reg_addr  <= reg_addr + ADDR_W'(1);
                  rd_req    <= 1'b1;
               end else begin
                  wr_valid  <= 1'b1;
                  wr_data   <= rx_word;
               end
            end
         end else if (shift_ok) begin
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
         end
      end
   end

   assign miso_oe = (state_q == DATA) && cmd_rw;
   assign miso    = miso_oe && tx_sh[DATA_W-1];

endmodule

// File: tb/tb_spi_bridge_sync.sv
// Directed scoreboard bench: a behavioural SPI master drives one bridge instance
// at a time; a monitor pops expected command/write/read events as they appear.
module tb_spi_bridge_sync;
   import spi_pkg::*;

   localparam int H = 8;
   localparam logic [1:0] EV_CMD = 2'd0;
   localparam logic [1:0] EV_WR  = 2'd1;
   localparam logic [1:0] EV_RD  = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [15:0] addr;
      logic [15:0] data;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mosi;
   logic [15:0] rd_data = '0;
   int          sel;
   int          n_checks = 0;
   int          n_fail   = 0;
   ev_t         sb[$];
   logic [15:0] rd_vals[$];

   logic       sclk8 [4];
   logic       cs_n8 [4];
   logic       miso8 [4];
   logic       oe8   [4];
   logic       cv8   [4];
   logic       rw8   [4];
   logic       wv8   [4];
   logic       rr8   [4];
   logic [5:0] addr8 [4];
   logic [7:0] wd8   [4];

   logic        sclk16, cs_n16, miso16, oe16, cv16, rw16, wv16, rr16;
   logic [9:0]  addr16;
   logic [15:0] wd16;

   logic        m_miso, m_oe, m_cv, m_rw, m_wv, m_rr;
   logic [15:0] m_addr, m_wd;

   always #5 clk = ~clk;

   for (genvar m = 0; m < 4; m++) begin : g_mode
      spi_bridge_sync #(
         .DATA_W(8), .ADDR_W(6), .CPOL(1'(m / 2)), .CPHA(1'(m % 2)), .SYNC_STAGES(2)
      ) u_dut (
         .clk(clk), .rst(rst), .sclk(sclk8[m]), .cs_n(cs_n8[m]), .mosi(mosi),
         .miso(miso8[m]), .miso_oe(oe8[m]), .cmd_valid(cv8[m]), .cmd_rw(rw8[m]),
         .reg_addr(addr8[m]), .wr_valid(wv8[m]), .wr_data(wd8[m]), .rd_req(rr8[m]),
         .rd_data(rd_data[7:0])
      );
   end

   spi_bridge_sync #(
      .DATA_W(16), .ADDR_W(10), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(3)
   ) u_dut16 (
      .clk(clk), .rst(rst), .sclk(sclk16), .cs_n(cs_n16), .mosi(mosi),
      .miso(miso16), .miso_oe(oe16), .cmd_valid(cv16), .cmd_rw(rw16),
      .reg_addr(addr16), .wr_valid(wv16), .wr_data(wd16), .rd_req(rr16),
      .rd_data(rd_data)
   );

   always_comb begin
      if (sel < 4) begin
         m_miso = miso8[sel]; m_oe = oe8[sel]; m_cv = cv8[sel]; m_rw = rw8[sel];
         m_wv   = wv8[sel];   m_rr = rr8[sel];
         m_addr = 16'(addr8[sel]); m_wd = 16'(wd8[sel]);
      end else begin
         m_miso = miso16; m_oe = oe16; m_cv = cv16; m_rw = rw16;
         m_wv   = wv16;   m_rr = rr16;
         m_addr = 16'(addr16); m_wd = wd16;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_ev(input logic [1:0] kind, input logic [15:0] addr, input logic [15:0] data);
      sb.push_back('{kind: kind, addr: addr, data: data});
   endtask

   task automatic got_ev(input logic [1:0] kind, input logic [15:0] addr, input logic [15:0] data);
      ev_t e;
      check("event_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("event_kind", 32'(kind), 32'(e.kind));
         check("event_addr", 32'(addr), 32'(e.addr));
         check("event_data", 32'(data), 32'(e.data));
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (m_cv) got_ev(EV_CMD, m_addr, 16'(m_rw));
         if (m_wv) got_ev(EV_WR, m_addr, m_wd);
         if (m_rr) begin
            got_ev(EV_RD, m_addr, 16'h0);
            rd_data = (rd_vals.size() != 0) ? rd_vals.pop_front() : 16'h0;
         end
         if (m_wv || m_rr) check("wr_rd_exclusive", 32'(m_wv & m_rr), 32'd0);
      end
   end

   function automatic logic cpol_of(input int d);
      return (d < 4) ? 1'(d / 2) : 1'b0;
   endfunction

   function automatic logic cpha_of(input int d);
      return (d < 4) ? 1'(d % 2) : 1'b0;
   endfunction

   task automatic half();
      repeat (H) @(negedge clk);
   endtask

   task automatic set_sclk(input int d, input logic v);
      if (d < 4) sclk8[d] = v;
      else       sclk16   = v;
   endtask

   task automatic set_cs(input int d, input logic v);
      if (d < 4) cs_n8[d] = v;
      else       cs_n16   = v;
   endtask

   task automatic select(input int d);
      sel = d;
      #1;
   endtask

   task automatic frame_begin(input int d);
      select(d);
      set_cs(d, 1'b0);
      half();
   endtask

   task automatic frame_end(input int d);
      half();
      set_cs(d, 1'b1);
      half();
      half();
   endtask

   // Master side: drives nb bits of w MSB-first and captures miso at each sample edge.
   task automatic spi_word(input int d, input logic [15:0] w, input int nb,
                           output logic [15:0] rx, output logic oe_all, output logic oe_any);
      logic cpol, cpha;
      cpol   = cpol_of(d);
      cpha   = cpha_of(d);
      rx     = '0;
      oe_all = 1'b1;
      oe_any = 1'b0;
      for (int i = nb - 1; i >= 0; i--) begin
         if (!cpha) begin
            mosi = w[i];
            half();
            rx = {rx[14:0], m_miso}; oe_all &= m_oe; oe_any |= m_oe;
            set_sclk(d, !cpol);
            half();
            set_sclk(d, cpol);
         end else begin
            set_sclk(d, !cpol);
            mosi = w[i];
            half();
            rx = {rx[14:0], m_miso}; oe_all &= m_oe; oe_any |= m_oe;
            set_sclk(d, cpol);
            half();
         end
      end
   endtask

   initial begin
      logic [15:0] rx, rx1;
      logic        oa, on;

      rst = 1'b1;
      mosi = 1'b0;
      sel = 0;
      for (int m = 0; m < 4; m++) begin
         sclk8[m] = 1'(m / 2);
         cs_n8[m] = 1'b1;
      end
      sclk16 = 1'b0;
      cs_n16 = 1'b1;

      repeat (3) @(negedge clk);
      for (int d = 0; d <= 4; d += 4) begin
         select(d);
         check("reset_ctrl", 32'({m_miso, m_oe, m_cv, m_rw, m_wv, m_rr}), 32'd0);
         check("reset_addr", 32'(m_addr), 32'd0);
         check("reset_wdata", 32'(m_wd), 32'd0);
      end
      check("reset_state", 32'(g_mode[0].u_dut.state_q), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Mode 0 single write.
      frame_begin(0);
      exp_ev(EV_CMD, 16'h05, 16'h0);
      spi_word(0, 16'h05, 8, rx, oa, on);
      exp_ev(EV_WR, 16'h05, 16'hA5);
      spi_word(0, 16'hA5, 8, rx, oa, on);
      frame_end(0);
      check("wr_m0_drained", 32'(sb.size()), 32'd0);
      check("wr_m0_addr_after", 32'(m_addr), 32'h06);
      check("wr_m0_rw", 32'(m_rw), 32'd0);

      // Mode 0 burst read with prefetch.
      rd_vals.push_back(16'h3C);
      rd_vals.push_back(16'hC3);
      frame_begin(0);
      exp_ev(EV_CMD, 16'h03, 16'h1);
      exp_ev(EV_RD, 16'h03, 16'h0);
      spi_word(0, 16'h83, 8, rx, oa, on);
      check("rd_cmd_oe_idle", 32'(on), 32'd0);
      exp_ev(EV_RD, 16'h04, 16'h0);
      spi_word(0, 16'h00, 8, rx1, oa, on);
      check("rd_word0_oe", 32'(oa), 32'd1);
      exp_ev(EV_RD, 16'h05, 16'h0);
      spi_word(0, 16'h00, 8, rx, oa, on);
      check("rd_word1_oe", 32'(oa), 32'd1);
      check("rd_miso_bits", 32'({rx1[7:0], rx[7:0]}), 32'h3CC3);
      frame_end(0);
      check("rd_oe_after", 32'({m_oe, m_miso}), 32'd0);
      check("rd_drained", 32'(sb.size()), 32'd0);
      check("rd_addr_after", 32'(m_addr), 32'h05);

      // Same write in every SPI mode.
      for (int m = 0; m < 4; m++) begin
         frame_begin(m);
         exp_ev(EV_CMD, 16'h11, 16'h0);
         spi_word(m, 16'h11, 8, rx, oa, on);
         exp_ev(EV_WR, 16'h11, 16'h5A);
         spi_word(m, 16'h5A, 8, rx, oa, on);
         frame_end(m);
         check("mode_drained", 32'(sb.size()), 32'd0);
         check("mode_addr_after", 32'(m_addr), 32'h12);
      end

      // Burst crossing the address wrap.
      frame_begin(0);
      exp_ev(EV_CMD, 16'h3F, 16'h0);
      spi_word(0, 16'h3F, 8, rx, oa, on);
      exp_ev(EV_WR, 16'h3F, 16'h11);
      spi_word(0, 16'h11, 8, rx, oa, on);
      exp_ev(EV_WR, 16'h00, 16'h22);
      spi_word(0, 16'h22, 8, rx, oa, on);
      exp_ev(EV_WR, 16'h01, 16'h33);
      spi_word(0, 16'h33, 8, rx, oa, on);
      frame_end(0);
      check("wrap_drained", 32'(sb.size()), 32'd0);
      check("wrap_addr_after", 32'(m_addr), 32'h02);

      // Abort after 5 data bits (mode 1), then a clean frame.
      frame_begin(1);
      exp_ev(EV_CMD, 16'h07, 16'h0);
      spi_word(1, 16'h07, 8, rx, oa, on);
      spi_word(1, 16'hFF, 5, rx, oa, on);
      frame_end(1);
      check("abort_drained", 32'(sb.size()), 32'd0);
      check("abort_state", 32'(g_mode[1].u_dut.state_q), 32'(IDLE));
      check("abort_addr_hold", 32'(m_addr), 32'h07);
      frame_begin(1);
      exp_ev(EV_CMD, 16'h09, 16'h0);
      spi_word(1, 16'h09, 8, rx, oa, on);
      exp_ev(EV_WR, 16'h09, 16'h77);
      spi_word(1, 16'h77, 8, rx, oa, on);
      frame_end(1);
      check("after_abort_drained", 32'(sb.size()), 32'd0);
      check("after_abort_addr", 32'(m_addr), 32'h0A);

      // 16-bit words, 10-bit address.
      frame_begin(4);
      exp_ev(EV_CMD, 16'h123, 16'h0);
      spi_word(4, 16'h0123, 16, rx, oa, on);
      exp_ev(EV_WR, 16'h123, 16'hBEEF);
      spi_word(4, 16'hBEEF, 16, rx, oa, on);
      frame_end(4);
      check("w16_drained", 32'(sb.size()), 32'd0);
      check("w16_addr_after", 32'(m_addr), 32'h124);

      // Reset mid-word: outputs clear, remainder of the frame is ignored.
      frame_begin(4);
      exp_ev(EV_CMD, 16'h45, 16'h0);
      spi_word(4, 16'h0045, 16, rx, oa, on);
      spi_word(4, 16'hFFFF, 6, rx, oa, on);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_ctrl", 32'({m_miso, m_oe, m_cv, m_rw, m_wv, m_rr}), 32'd0);
      check("rst_mid_addr", 32'(m_addr), 32'd0);
      check("rst_mid_wdata", 32'(m_wd), 32'd0);
      check("rst_mid_state", 32'(u_dut16.state_q), 32'(IDLE));
      rst = 1'b0;
      spi_word(4, 16'hFFFF, 10, rx, oa, on);
      spi_word(4, 16'h8001, 16, rx, oa, on);
      frame_end(4);
      check("rst_frame_ignored", 32'(sb.size()), 32'd0);
      frame_begin(4);
      exp_ev(EV_CMD, 16'h56, 16'h0);
      spi_word(4, 16'h0056, 16, rx, oa, on);
      exp_ev(EV_WR, 16'h56, 16'h1234);
      spi_word(4, 16'h1234, 16, rx, oa, on);
      frame_end(4);
      check("post_rst_drained", 32'(sb.size()), 32'd0);
      check("post_rst_addr", 32'(m_addr), 32'h57);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_bridge_sync.md
Name: spi_bridge_sync

Overview:
- Parametrised SPI slave bridge, fully in the `clk` domain. `sclk`, `cs_n` and `mosi` are oversampled through synchronisers; edge detection replaces SCLK-clocked logic.
- Decodes a command word (read/write flag plus register address), then streams DATA_W-bit data words with address auto-increment.
- Sits between the external SPI master and the PWM register file.
- Adds over the single-byte bridge: configurable word width, configurable SPI mode, burst transfers, and a clean per-frame reset on `cs_n`.

Parameters:
- DATA_W, 8, bits per SPI word; command and data words have equal width.
- ADDR_W, 6, address field width; must be ≤ DATA_W-1.
- CPOL, 0, SCLK idle level.
- CPHA, 0: sample on leading edge, shift on trailing. 1: shift on leading, sample on trailing.
- SYNC_STAGES, 2, synchroniser flops per SPI input (≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- sclk  in  1  SPI clock, asynchronous
- cs_n  in  1  SPI chip select, active low, asynchronous
- mosi  in  1  SPI data from master
- miso  out  1  SPI data to master
- miso_oe  out  1  MISO output enable
- cmd_valid  out  1  1-cycle pulse: command word decoded
- cmd_rw  out  1  1 = read (bridge drives MISO), 0 = write; held until next cmd_valid
- reg_addr  out  ADDR_W  current register address
- wr_valid  out  1  1-cycle pulse: wr_data valid for reg_addr
- wr_data  out  DATA_W  received data word
- rd_req  out  1  1-cycle pulse: register file must present rd_data for reg_addr
- rd_data  in  DATA_W  read data, sampled exactly 1 clk after rd_req

Behaviour:
- Reset (rst=1 at posedge clk): all outputs 0, FSM=IDLE, shift registers and bit counter 0, synchroniser flops loaded with idle values (sclk=CPOL, cs_n=1, mosi=0).
- Edge detect: compare last two synchronised sclk samples. Leading edge = transition away from CPOL. Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- Timing requirement: SCLK high and low phases are each ≥ SYNC_STAGES+3 clk.
- FSM states: IDLE, CMD, DATA.
  - IDLE → CMD on synchronised cs_n falling; bit counter cleared.
  - CMD: shift mosi in MSB-first on each sample edge. On the DATA_W-th sample:
    - pulse cmd_valid.
    - cmd_rw = word[DATA_W-1].
    - reg_addr = word[ADDR_W-1:0]; remaining bits ignored.
    - → DATA.
    - If read: pulse rd_req in the same cycle.
  - DATA, write: shift mosi in. On the DATA_W-th sample, pulse wr_valid with wr_data = word, and increment reg_addr in the following cycle.
  - DATA, read:
    - Load rd_data into the tx shifter 1 clk after rd_req. miso = tx[DATA_W-1], shifted left on each shift edge; mosi ignored.
    - On the DATA_W-th sample edge, increment reg_addr and pulse rd_req; the next word is loaded before the next word's first bit is needed.
    - CPHA=1: the first shift edge of each word does not shift; it only presents the MSB already loaded.
- Address wrap: reg_addr increments modulo 2^ADDR_W (all-ones → 0).
- Bit counter: 0..DATA_W-1, wraps to 0 at each word boundary.
- cs_n rise (synchronised) in any state:
  - → IDLE in the same cycle.
  - Partial word discarded; no wr_valid or rd_req for it.
  - miso_oe=0, miso=0.
  - cmd_rw and reg_addr hold their values.
- Sample edge coincident with cs_n rise: the cs_n rise wins.
- miso_oe = 1 only in DATA with cmd_rw=1. miso = 0 whenever miso_oe = 0.
- rst asserted mid-frame: immediate return to the reset state. The rest of that frame is ignored until cs_n has been seen high, then low again.
- Pulses are never asserted for more than 1 clk. wr_valid and rd_req are never asserted together.

Decomposition:
- Shared package `spi_pkg`: FSM state enum (IDLE/CMD/DATA), mode constants (MODE0..MODE3 as CPOL/CPHA pairs), RW bit position constant.
- One natural sub-module: `spi_sync_edge` — N-stage synchroniser for sclk/cs_n/mosi. Outputs synchronised levels, sample_edge, shift_edge, cs_fall and cs_rise strobes.

Test Plan:
- Mode 0, DATA_W=8: cs_n low; send 0x05 then 0xA5; cs_n high → cmd_valid with cmd_rw=0, reg_addr=5; one wr_valid with wr_data=0xA5, reg_addr=5; reg_addr=6 afterwards.
- Mode 0, read: send 0x83 with rd_data model returning 0x3C, 0xC3 → rd_req for address 3; MISO bits over 16 clocks = 00111100 11000011; miso_oe high only during data words.
- Modes 1, 2, 3: repeat the write of 0x5A to address 0x11 → identical wr_valid/wr_data/reg_addr in every mode.
- Burst wrap, ADDR_W=6: write command to 0x3F followed by 3 data words → wr_valid at addresses 0x3F, 0x00, 0x01.
- Abort: cs_n rises after 5 bits of a data word → no wr_valid; FSM=IDLE; next frame decodes a new command correctly.
- DATA_W=16, ADDR_W=10: command 0x0123 then data 0xBEEF → reg_addr=0x123, wr_data=0xBEEF. Also assert rst mid-word → all outputs 0 next cycle.
